rx_frame_sequencer: RTL and testbench
=====================================

RX_FRAME_SEQUENCER -- requirements
Module: rx_frame_sequencer

Interface
REQ-001 Parameter OSR, default 4: clocks per serial bit; legal values are even and >= 2.
REQ-002 Parameter DATA_BITS, default 4: data bits per frame; legal range 1..16.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 rx_en  input  1  receive enable; when low, no new frame starts.
REQ-006 rx_data  input  1  serial line, idle high; already synchronous to clk.
REQ-007 out_data  output  DATA_BITS  received word, bit 0 = first data bit received.
REQ-008 out_valid  output  1  out_data holds an unconsumed word.
REQ-009 out_ready  input  1  consumer accepts the word when out_valid && out_ready at a clock edge.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 overrun  output  1  one-cycle pulse: a good frame was dropped because the holding register was full.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 Frame format: start bit (0), then DATA_BITS data bits LSB first, then one stop bit (1).
REQ-014 FSM states: IDLE, START, DATA, STOP; encoding is an implementation choice.
REQ-015 Internal counters:
- clk_cnt, width clog2(OSR), clears on every state entry;
- bit_cnt, width clog2(DATA_BITS+1).
REQ-016 IDLE -> START at edge t0 when rx_en=1 and rx_data=0; clk_cnt=0.
REQ-017 START sampling: clk_cnt increments each cycle; rx_data is sampled at the edge where clk_cnt==OSR/2-1 (edge t0+OSR/2).
- Sample 0 -> DATA, clk_cnt=0, bit_cnt=0.
- Sample 1 -> IDLE (false start); no pulse, no output change.
REQ-018 DATA: rx_data is sampled at each edge where clk_cnt==OSR-1, i.e. every OSR clocks.
- Each sample shifts in at the MSB side, so the first bit ends in bit 0.
- bit_cnt increments and clk_cnt wraps to 0 on each sample.
- After the DATA_BITS-th sample -> STOP.
REQ-019 STOP: rx_data is sampled at clk_cnt==OSR-1, at edge t0+OSR/2+(DATA_BITS+1)*OSR (22 clocks for the defaults); the FSM then -> IDLE.
- Sample 1: good frame.
- Sample 0: frame_err=1 for exactly the following cycle; data discarded; out_valid/out_data unchanged.
REQ-020 Good frame with out_valid=0: out_data loaded and out_valid=1 from the stop-sample edge onward.
REQ-021 Good frame with out_valid=1 and out_ready=1 on the same edge: old word consumed, new word loaded, out_valid stays 1.
REQ-022 Good frame with out_valid=1 and out_ready=0: new word dropped; overrun=1 for one cycle; old word retained.
REQ-023 out_valid deasserts on the edge where out_valid && out_ready and no good frame completes.
- out_data is stable while out_valid=1 and out_ready=0.
REQ-024 rx_en=0 in START/DATA/STOP aborts to IDLE on the next edge.
- No pulse is generated; the partial word is discarded.
- out_valid/out_data are unaffected.
REQ-025 Back-to-back frames: IDLE accepts a new start bit on the first edge after returning from STOP.
REQ-026 frame_err and overrun are never asserted in the same cycle.

Reset
REQ-027 rstn=0 asynchronously forces:
- FSM=IDLE, clk_cnt=0, bit_cnt=0, shift register=0;
- out_data=0, out_valid=0, frame_err=0, overrun=0, busy=0.
REQ-028 Reset mid-frame discards the partial frame; after release the block waits for a new start bit.
REQ-029 out_ready is ignored while rstn=0.

Verification
REQ-030 Good frame: OSR=4, DATA_BITS=4, rx_en=1, out_ready=0; send data bits 0,1,0,1 -> out_data=4'b1010, out_valid=1 at edge t0+22, frame_err=0.
REQ-031 Framing error: same frame with stop bit=0 -> frame_err pulse of exactly 1 cycle after edge t0+22; out_valid stays 0; next good frame is received correctly.
REQ-032 False start: 1-clock low glitch on rx_data while idle -> FSM returns to IDLE at edge t0+2; no outputs change.
REQ-033 Overrun and simultaneous accept:
- Hold out_ready=0 over two good frames (4'h3 then 4'h5) -> overrun pulse at the second stop sample; out_data stays 4'h3.
- Repeat with out_ready=1 at the second stop edge -> out_data=4'h5, out_valid stays 1.
REQ-034 Abort: deassert rx_en mid-DATA -> busy=0 next cycle; no pulses; out_valid unchanged.
REQ-035 Reset mid-frame: assert rstn=0 during DATA with out_valid=1 -> all outputs 0 immediately, without waiting for a clock edge; the next full frame after release is received correctly.

Source files
------------

// File: rtl/rx_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_sequencer
//  Description : Oversampled serial frame receiver. It takes a start bit,
//                DATA_BITS data bits (LSB first) and one stop bit. It keeps
//                one holding register with a valid/ready handshake, and it
//                pulses frame_err and overrun for one cycle each.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_sequencer #(
    parameter int OSR       = 4,   // clocks per serial bit, even and >= 2
    parameter int DATA_BITS = 4    // data bits per frame, 1..16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx_en,
    input  logic                 rx_data,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_CW = $clog2(OSR);
    localparam int c_BW = $clog2(DATA_BITS + 1);

    // Sample points: mid start bit, then once per bit period.
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(OSR / 2 - 1);
    localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(OSR - 1);
    localparam logic [c_BW-1:0] c_WORD_LAST = c_BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CW-1:0]      r_clk_cnt;
    logic [c_CW-1:0]      w_clk_cnt_next;
    logic [c_BW-1:0]      r_bit_cnt;
    logic [c_BW-1:0]      w_bit_cnt_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_in;
    logic                 w_shift_en;
    logic                 w_stop_sample;
    logic                 w_good;
    logic                 w_bad;

    // New bits enter at the MSB side, so the first received bit ends in bit 0.
    generate
        if (DATA_BITS == 1) begin : g_shift_single
            assign w_shift_in = rx_data;
        end else begin : g_shift_multi
            assign w_shift_in = {rx_data, r_shift[DATA_BITS-1:1]};
        end
    endgenerate

    // State, counter and shift-register update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clk_cnt <= w_clk_cnt_next;
            r_bit_cnt <= w_bit_cnt_next;
            if (w_shift_en) begin
                r_shift <= w_shift_in;
            end
        end
    end

    // Next state and sampling strobes. Dropping rx_en wins over a sample.
    always_comb begin
        w_state_next   = r_state;
        w_clk_cnt_next = r_clk_cnt + c_CW'(1);
        w_bit_cnt_next = r_bit_cnt;
        w_shift_en     = 1'b0;
        w_stop_sample  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clk_cnt_next = '0;
                if (rx_en && !rx_data) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (!rx_en) begin
                    w_state_next   = ST_IDLE;
                    w_clk_cnt_next = '0;
                end else if (r_clk_cnt == c_HALF_LAST) begin
                    // A line that is back high at mid-bit is only a glitch.
                    w_state_next   = rx_data ? ST_IDLE : ST_DATA;
                    w_clk_cnt_next = '0;
                    w_bit_cnt_next = '0;
                end
            end
            ST_DATA: begin
                if (!rx_en) begin
                    w_state_next   = ST_IDLE;
                    w_clk_cnt_next = '0;
                end else if (r_clk_cnt == c_BIT_LAST) begin
                    w_shift_en     = 1'b1;
                    w_clk_cnt_next = '0;
                    w_bit_cnt_next = r_bit_cnt + c_BW'(1);
                    if (r_bit_cnt == c_WORD_LAST) begin
                        w_state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (!rx_en) begin
                    w_state_next   = ST_IDLE;
                    w_clk_cnt_next = '0;
                end else if (r_clk_cnt == c_BIT_LAST) begin
                    w_stop_sample  = 1'b1;
                    w_state_next   = ST_IDLE;
                    w_clk_cnt_next = '0;
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_clk_cnt_next = '0;
            end
        endcase
    end

    assign w_good = w_stop_sample && rx_data;
    assign w_bad  = w_stop_sample && !rx_data;

    // Holding register, handshake and one-cycle status pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= w_bad;
            overrun   <= w_good && out_valid && !out_ready;
            if (w_good && (!out_valid || out_ready)) begin
                out_data  <= r_shift;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_frame_sequencer
//  Description : Directed self-checking bench for rx_frame_sequencer
//                (OSR=4, DATA_BITS=4) with hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_sequencer;

    localparam int OSR       = 4;
    localparam int DATA_BITS = 4;

    logic                 clk;
    logic                 rstn;
    logic                 rx_en;
    logic                 rx_data;
    logic                 out_ready;
    logic [DATA_BITS-1:0] out_data;
    logic                 out_valid;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    int n_compared;
    int n_mismatched;

    rx_frame_sequencer #(
        .OSR       (OSR),
        .DATA_BITS (DATA_BITS)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx_en     (rx_en),
        .rx_data   (rx_data),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Drive start + data bits + stop bit, stopping just before the stop-sample
    // edge (t0+22). The caller performs that edge itself.
    task automatic send_to_stop(input logic [DATA_BITS-1:0] d, input logic stop);
        rx_data = 1'b0;
        ticks(OSR);
        for (int b = 0; b < DATA_BITS; b++) begin
            rx_data = d[b];
            ticks(OSR);
        end
        rx_data = stop;
        ticks(OSR / 2);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rstn      = 1'b1;
        rx_en     = 1'b1;
        rx_data   = 1'b1;
        out_ready = 1'b0;

        // Reset state, applied between clock edges.
        #2 rstn = 1'b0;
        #1;
        check_val("reset_out_valid", out_valid, 0);
        check_val("reset_out_data",  out_data,  0);
        check_val("reset_busy",      busy,      0);
        check_val("reset_flags",     {frame_err, overrun}, 0);
        out_ready = 1'b1;
        ticks(2);
        check_val("reset_ready_ignored", out_valid, 0);
        out_ready = 1'b0;
        rstn = 1'b1;
        ticks(2);

        // Good frame: bits 0,1,0,1 -> 4'b1010.
        send_to_stop(4'hA, 1'b1);
        check_val("good_busy_before_stop",  busy,      1);
        check_val("good_valid_before_stop", out_valid, 0);
        tick();
        rx_data = 1'b1;
        check_val("good_out_valid", out_valid, 1);
        check_val("good_out_data",  out_data,  4'hA);
        check_val("good_frame_err", frame_err, 0);
        check_val("good_busy_after", busy, 0);
        tick();
        check_val("good_data_held", out_data, 4'hA);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("consume_valid_low", out_valid, 0);

        // Framing error, then a good frame.
        send_to_stop(4'hA, 1'b0);
        check_val("ferr_before", frame_err, 0);
        tick();
        rx_data = 1'b1;
        check_val("ferr_pulse",       frame_err, 1);
        check_val("ferr_valid_low",   out_valid, 0);
        check_val("ferr_no_overrun",  overrun,   0);
        tick();
        check_val("ferr_pulse_end",   frame_err, 0);
        send_to_stop(4'h6, 1'b1);
        tick();
        rx_data = 1'b1;
        check_val("after_ferr_valid", out_valid, 1);
        check_val("after_ferr_data",  out_data,  4'h6);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("consume2_valid_low", out_valid, 0);

        // False start: one-clock low glitch.
        rx_data = 1'b0;
        tick();
        rx_data = 1'b1;
        check_val("glitch_busy_t0", busy, 1);
        tick();
        check_val("glitch_busy_t1", busy, 1);
        tick();
        check_val("glitch_idle_t2",  busy, 0);
        check_val("glitch_outputs", {out_valid, frame_err, overrun}, 0);
        ticks(3);
        check_val("glitch_still_idle", busy, 0);

        // Overrun: 4'h3 then back-to-back 4'h5 with out_ready low.
        send_to_stop(4'h3, 1'b1);
        tick();
        check_val("ovr_first_data", out_data, 4'h3);
        send_to_stop(4'h5, 1'b1);
        tick();
        rx_data = 1'b1;
        check_val("ovr_pulse",      overrun,   1);
        check_val("ovr_no_ferr",    frame_err, 0);
        check_val("ovr_data_kept",  out_data,  4'h3);
        check_val("ovr_valid_kept", out_valid, 1);
        tick();
        check_val("ovr_pulse_end",  overrun,   0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("consume3_valid_low", out_valid, 0);

        // Simultaneous accept and load at the second stop edge.
        send_to_stop(4'h3, 1'b1);
        tick();
        rx_data = 1'b1;
        check_val("sim_first_data", out_data, 4'h3);
        send_to_stop(4'h5, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        rx_data = 1'b1;
        check_val("sim_data_new",   out_data,  4'h5);
        check_val("sim_valid_kept", out_valid, 1);
        check_val("sim_no_overrun", overrun,   0);

        // Abort mid-DATA by dropping rx_en.
        rx_data = 1'b0;
        ticks(OSR);
        rx_data = 1'b1;
        ticks(OSR);
        check_val("abort_busy_before", busy, 1);
        rx_en = 1'b0;
        tick();
        check_val("abort_busy_after", busy, 0);
        check_val("abort_no_pulses", {frame_err, overrun}, 0);
        check_val("abort_valid_kept", out_valid, 1);
        check_val("abort_data_kept",  out_data,  4'h5);
        rx_data = 1'b0;
        tick();
        check_val("disabled_no_start", busy, 0);
        rx_data = 1'b1;
        rx_en = 1'b1;
        ticks(2);

        // Asynchronous reset mid-frame with out_valid high.
        rx_data = 1'b0;
        ticks(OSR);
        rx_data = 1'b0;
        ticks(OSR);
        check_val("rst_mid_valid_before", out_valid, 1);
        #2 rstn = 1'b0;
        #1;
        check_val("rst_mid_valid", out_valid, 0);
        check_val("rst_mid_data",  out_data,  0);
        check_val("rst_mid_busy",  busy,      0);
        rx_data = 1'b1;
        #1 rstn = 1'b1;
        ticks(3);
        check_val("rst_release_idle", busy, 0);
        send_to_stop(4'hC, 1'b1);
        tick();
        rx_data = 1'b1;
        check_val("post_rst_valid", out_valid, 1);
        check_val("post_rst_data",  out_data,  4'hC);
        ticks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
